credit_flit_injector: RTL
=========================

// Module: credit_flit_injector
// PURPOSE
//  Upstream transmitter for one router input port: buffers flits from a local source, drives
//  input_data/input_valid of a router_top port, and consumes that port's upstr_router_increment.
//  Tracks downstream VC-buffer credits and never sends more flits than free VC buffers.
//  Sits in the network interface, or on the output side of a neighbouring router, feeding router_top.
// PARAMETERS
//  NUM_VC      4                 VC buffers at the receiving port; initial/maximum credit count
//  FIFO_DEPTH  8                 local flit FIFO entries; power of 2, >=2
//  DATA_W      `FLIT_DATA_WIDTH  flit width, from VR_define.vh
// PORTS
//  clk               input   1                      clock; all state updates on rising edge
//  reset             input   1                      synchronous, active-high
//  src_data          input   DATA_W                 flit from local source
//  src_valid         input   1                      src_data valid
//  src_ready         output  1                      FIFO can accept; = !fifo_full (combinational)
//  out_data          output  DATA_W                 to router_top input_data[p]
//  out_valid         output  1                      to router_top input_valid[p]; 1-cycle pulse per flit
//  credit_increment  input   1                      from router_top upstr_router_increment[p]; +1 credit
//  credit_count      output  $clog2(NUM_VC+1)       current credits
//  fifo_count        output  $clog2(FIFO_DEPTH+1)   FIFO occupancy
//  credit_error      output  1                      sticky: credit_increment seen at credit_count==NUM_VC
// BEHAVIOUR
//  Reset values: FIFO empty, fifo_count=0, credit_count=NUM_VC, out_valid=0, out_data=0,
//   credit_error=0, state=IDLE. Reset mid-operation discards all buffered flits; credits return to NUM_VC.
//  Push: src_valid && src_ready at an edge writes src_data at the tail. At full, src_ready=0 and the flit
//   is not taken; the source holds it.
//  Send condition at edge t: FIFO non-empty before edge t && credit_count>0 before edge t.
//   When it holds: pop head, register out_data=head, out_valid=1 after t, credit_count-1.
//   Otherwise out_valid=0 after t; out_data keeps its last value.
//  Latency: flit pushed into an empty FIFO at edge t with credits>0 is on out_data/out_valid after edge t+1.
//   No same-edge bypass. Throughput is 1 flit/cycle while credits last.
//  Push and pop at the same edge: both happen; fifo_count unchanged. A push at full is blocked even if a
//   pop happens at that edge, because src_ready is derived from full only.
//  Credits: next = cur - send + credit_increment, computed in one step.
//   Send and increment at the same edge: count unchanged.
//   Increment at NUM_VC with no send: saturate at NUM_VC and set credit_error (cleared only by reset).
//   The decrement never underflows because sending requires credit_count>0.
//  FSM (observable via hierarchical ref `state`):
//   IDLE  = FIFO empty
//   SEND  = FIFO non-empty, credits>0
//   STALL = FIFO non-empty, credits==0
//   The state is recomputed every edge from next FIFO and credit values.
//   Transitions:
//    IDLE->SEND on push with credits>0
//    IDLE->STALL on push with credits==0
//    SEND->STALL when last credit is used with FIFO still non-empty
//    SEND->IDLE on last pop
//    STALL->SEND on credit_increment
//  FIFO: circular buffer of FIFO_DEPTH entries; pointers are $clog2(FIFO_DEPTH) bits and wrap modulo
//   depth. fifo_count is a separate counter, with full=(count==FIFO_DEPTH) and empty=(count==0).
// TESTING
//  1 Reset: hold reset 2 cycles -> credit_count=4, fifo_count=0, out_valid=0, src_ready=1, credit_error=0.
//  2 Burst: push 0xA1..0xA6 back-to-back, no increments -> out_valid exactly 4 pulses (A1..A4),
//    starting 1 cycle after first push; credit_count=0; fifo_count=2; state=STALL.
//  3 Release: from (2), pulse credit_increment once -> A5 sent the next edge, credit_count back to 0;
//    second pulse -> A6 sent; state=IDLE.
//  4 Full: credit_count=0, push 9 flits -> src_ready=0 after 8th, fifo_count=8, 9th held;
//    then 8 increments -> flits exit in order and pointers wrap.
//  5 Simultaneous: send with credit_increment on the same edge -> credit_count unchanged;
//    increment at credit_count=4 -> stays 4, credit_error=1 and stays set.
//  6 Reset mid-burst: reset asserted with fifo_count=5, credit_count=1 -> next cycle FIFO empty,
//    credits=4, out_valid=0, and no stale flit is emitted afterwards.

Source files
------------

// File: rtl/credit_flit_injector.sv
// Credit-based flit injector: buffers local flits and sends them to a router input port
// only while the downstream VC buffers have free credits.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module credit_flit_injector #(
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = `FLIT_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               src_data,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            credit_increment,
  output logic [$clog2(NUM_VC+1)-1:0]     credit_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            credit_error
);

  localparam int unsigned CW = $clog2(NUM_VC + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StStall = 2'd2
  } state_e;

  state_e state;
  state_e w_state_next;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [FW-1:0]     r_count;
  logic [CW-1:0]     r_credit;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_credit_error;

  logic              w_full;
  logic              w_push;
  logic              w_send;
  logic [FW-1:0]     w_count_next;
  logic [CW-1:0]     w_credit_next;
  logic              w_credit_overflow;

  assign w_full       = (r_count == FW'(FIFO_DEPTH));
  assign w_push       = src_valid && !w_full;
  assign src_ready    = !w_full;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign credit_count = r_credit;
  assign fifo_count   = r_count;
  assign credit_error = r_credit_error;

  // State always mirrors the registered FIFO/credit values, so SEND is exactly the send condition.
  always_comb begin
    w_send = (state == StSend);
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_send) begin
      w_count_next = r_count + FW'(1);
    end else if (!w_push && w_send) begin
      w_count_next = r_count - FW'(1);
    end
  end

  always_comb begin
    w_credit_next     = r_credit;
    w_credit_overflow = 1'b0;
    if (w_send && !credit_increment) begin
      w_credit_next = r_credit - CW'(1);
    end else if (!w_send && credit_increment) begin
      if (r_credit == CW'(NUM_VC)) begin
        w_credit_overflow = 1'b1;
      end else begin
        w_credit_next = r_credit + CW'(1);
      end
    end
  end

  always_comb begin
    if (w_count_next == '0) begin
      w_state_next = StIdle;
    end else if (w_credit_next == '0) begin
      w_state_next = StStall;
    end else begin
      w_state_next = StSend;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_credit       <= CW'(NUM_VC);
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_credit_error <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_credit    <= w_credit_next;
      r_out_valid <= w_send;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_send) begin
        r_out_data <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PW'(1);
      end
      if (w_credit_overflow) begin
        r_credit_error <= 1'b1;
      end
    end
  end

endmodule
